// File: rtl/s2p_frame_receiver.sv
// s2p_frame_receiver
// Collects framed serial bits MSB-first into N-bit parallel words.
// A frame is exactly N accepted bits with s_last on the Nth bit. Any other
// framing discards the partial word and raises a one-cycle frame_err pulse.
// A single holding register lets the next word assemble while the current
// word waits for downstream.
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   s_data    : serial data bit
//   s_valid   : s_data / s_last qualify this cycle
//   s_last    : final bit of a frame
//   s_ready   : receiver takes a serial bit this cycle (combinational)
//   p_data    : assembled parallel word
//   p_valid   : p_data holds an undelivered word
//   p_ready   : downstream takes p_data this cycle
//   frame_err : one-cycle pulse per framing violation
//   err_count : saturating count of framing violations
module s2p_frame_receiver #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_data,
  input  logic         s_valid,
  input  logic         s_last,
  output logic         s_ready,
  output logic [N-1:0] p_data,
  output logic         p_valid,
  input  logic         p_ready,
  output logic         frame_err,
  output logic [7:0]   err_count
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [N-1:0]  shift_r, shift_nxt_s;
  logic [N-1:0]  p_data_r, p_data_nxt_s;
  logic          p_valid_r, p_valid_nxt_s;
  logic          frame_err_r, frame_err_nxt_s;
  logic [7:0]    err_count_r, err_count_nxt_s;

  logic          last_pos_s;
  logic          accept_s;
  logic          drain_s;
  logic [N-1:0]  word_s;

  // Handshake qualifiers. The final bit position is only blocked when the
  // holding register is full and will not empty this cycle.
  always_comb begin
    last_pos_s = (cnt_r == CNT_MAX);
    s_ready    = !last_pos_s || !p_valid_r || p_ready;
    accept_s   = s_valid && s_ready;
    drain_s    = p_valid_r && p_ready;
    word_s     = {shift_r[N-2:0], s_data};
  end

  // Next-state computation for assembly, holding register and error tracking.
  always_comb begin
    cnt_nxt_s       = cnt_r;
    shift_nxt_s     = shift_r;
    p_data_nxt_s    = p_data_r;
    p_valid_nxt_s   = p_valid_r;
    frame_err_nxt_s = 1'b0;
    err_count_nxt_s = err_count_r;

    if (drain_s) begin
      p_valid_nxt_s = 1'b0;
    end else begin
      p_valid_nxt_s = p_valid_r;
    end

    if (accept_s) begin
      if (!last_pos_s && !s_last) begin
        shift_nxt_s = word_s;
        cnt_nxt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end else if (last_pos_s && s_last) begin
        // Load wins over a same-cycle drain, so back-to-back words see no bubble.
        p_data_nxt_s  = word_s;
        p_valid_nxt_s = 1'b1;
        shift_nxt_s   = {N{1'b0}};
        cnt_nxt_s     = {CW{1'b0}};
      end else begin
        // Early or missing s_last: drop the partial word, leave output alone.
        shift_nxt_s     = {N{1'b0}};
        cnt_nxt_s       = {CW{1'b0}};
        frame_err_nxt_s = 1'b1;
        if (err_count_r != 8'hFF) begin
          err_count_nxt_s = err_count_r + 8'd1;
        end else begin
          err_count_nxt_s = err_count_r;
        end
      end
    end else begin
      cnt_nxt_s   = cnt_r;
      shift_nxt_s = shift_r;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r       <= {CW{1'b0}};
      shift_r     <= {N{1'b0}};
      p_data_r    <= {N{1'b0}};
      p_valid_r   <= 1'b0;
      frame_err_r <= 1'b0;
      err_count_r <= 8'd0;
    end else begin
      cnt_r       <= cnt_nxt_s;
      shift_r     <= shift_nxt_s;
      p_data_r    <= p_data_nxt_s;
      p_valid_r   <= p_valid_nxt_s;
      frame_err_r <= frame_err_nxt_s;
      err_count_r <= err_count_nxt_s;
    end
  end

  assign p_data    = p_data_r;
  assign p_valid   = p_valid_r;
  assign frame_err = frame_err_r;
  assign err_count = err_count_r;

endmodule

// File: tb/tb_s2p_frame_receiver.sv
// Directed testbench for s2p_frame_receiver with N=4.
module tb_s2p_frame_receiver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic [3:0] p_data;
  logic       p_valid;
  logic       p_ready;
  logic       frame_err;
  logic [7:0] err_count;

  int checks_cnt = 0;
  int errors_cnt = 0;

  s2p_frame_receiver #(.N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .p_data    (p_data),
    .p_valid   (p_valid),
    .p_ready   (p_ready),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 unit after the
  // edge on which the bit was taken.
  task automatic send_bit(input logic d, input logic l);
    int n;
    logic timed_out;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    #1;
    while (!s_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    timed_out = (n >= 50);
    check_val("hs_timeout", {31'd0, timed_out}, 32'd0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic idle(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 1'b1;
    s_last  = 1'b1;
    p_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Reset state with traffic offered: nothing taken.
    check_val("rst_p_valid", {31'd0, p_valid}, 32'd0);
    check_val("rst_p_data", {28'd0, p_data}, 32'd0);
    check_val("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check_val("rst_err_count", {24'd0, err_count}, 32'd0);
    check_val("rst_s_ready", {31'd0, s_ready}, 32'd1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    rst_n   = 1'b1;
    idle(1);

    // Basic frame 1,0,1,1.
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    check_val("f1_no_early_valid", {31'd0, p_valid}, 32'd0);
    send_bit(1'b1, 1'b1);
    check_val("f1_p_valid", {31'd0, p_valid}, 32'd1);
    check_val("f1_p_data", {28'd0, p_data}, 32'hB);
    check_val("f1_frame_err", {31'd0, frame_err}, 32'd0);
    idle(1);
    check_val("f1_drained", {31'd0, p_valid}, 32'd0);

    // Backpressure: hold 0xA, assemble 0,1,0 then stall on final bit.
    p_ready = 1'b0;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    check_val("bp_hold_valid", {31'd0, p_valid}, 32'd1);
    check_val("bp_hold_data", {28'd0, p_data}, 32'hA);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    s_valid = 1'b1;
    s_data  = 1'b1;
    s_last  = 1'b1;
    idle(2);
    check_val("bp_s_ready_low", {31'd0, s_ready}, 32'd0);
    check_val("bp_stable_data", {28'd0, p_data}, 32'hA);
    check_val("bp_stable_valid", {31'd0, p_valid}, 32'd1);
    p_ready = 1'b1;
    #1;
    check_val("bp_s_ready_high", {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    check_val("bp_reload_valid", {31'd0, p_valid}, 32'd1);
    check_val("bp_reload_data", {28'd0, p_data}, 32'h5);
    idle(1);
    check_val("bp_final_drain", {31'd0, p_valid}, 32'd0);

    // Early last on the 2nd bit, then a good frame with idle gaps.
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    check_val("el_frame_err", {31'd0, frame_err}, 32'd1);
    check_val("el_err_count", {24'd0, err_count}, 32'd1);
    check_val("el_no_valid", {31'd0, p_valid}, 32'd0);
    idle(1);
    check_val("el_pulse_end", {31'd0, frame_err}, 32'd0);
    send_bit(1'b1, 1'b0);
    idle(3);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    idle(2);
    send_bit(1'b0, 1'b1);
    check_val("el_good_valid", {31'd0, p_valid}, 32'd1);
    check_val("el_good_data", {28'd0, p_data}, 32'hC);
    idle(1);

    // Missing last on the 4th bit.
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check_val("ml_frame_err", {31'd0, frame_err}, 32'd1);
    check_val("ml_err_count", {24'd0, err_count}, 32'd2);
    check_val("ml_no_valid", {31'd0, p_valid}, 32'd0);
    check_val("ml_data_kept", {28'd0, p_data}, 32'hC);
    idle(1);
    check_val("ml_pulse_end", {31'd0, frame_err}, 32'd0);

    // Saturation: 258 more violations, 260 in total.
    for (int i = 0; i < 253; i++) send_bit(1'b0, 1'b1);
    check_val("sat_reach", {24'd0, err_count}, 32'd255);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
    check_val("sat_hold", {24'd0, err_count}, 32'd255);
    check_val("sat_pulse", {31'd0, frame_err}, 32'd1);

    // Reset mid-frame with an undelivered word.
    p_ready = 1'b0;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check_val("pr_valid", {31'd0, p_valid}, 32'd1);
    check_val("pr_data", {28'd0, p_data}, 32'hF);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("ar_p_valid", {31'd0, p_valid}, 32'd0);
    check_val("ar_p_data", {28'd0, p_data}, 32'd0);
    check_val("ar_err_count", {24'd0, err_count}, 32'd0);
    check_val("ar_frame_err", {31'd0, frame_err}, 32'd0);
    check_val("ar_s_ready", {31'd0, s_ready}, 32'd1);
    @(negedge clk);
    rst_n   = 1'b1;
    p_ready = 1'b1;
    @(posedge clk);
    #1;
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    check_val("ar_new_valid", {31'd0, p_valid}, 32'd1);
    check_val("ar_new_data", {28'd0, p_data}, 32'h1);
    check_val("ar_new_err", {31'd0, frame_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/s2p_frame_receiver.md
S2P_FRAME_RECEIVER -- requirements
Module: s2p_frame_receiver

Interface
REQ-001 SHALL have parameter N, default 4: parallel word width in bits (N >= 2).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-004 SHALL have port s_data, input, 1: serial data bit.
REQ-005 SHALL have port s_valid, input, 1: s_data/s_last valid.
REQ-006 SHALL have port s_last, input, 1: marks final bit of a frame.
REQ-007 SHALL have port s_ready, output, 1: receiver accepts a serial bit this cycle.
REQ-008 SHALL have port p_data, output, N: assembled parallel word.
REQ-009 SHALL have port p_valid, output, 1: p_data holds an undelivered word.
REQ-010 SHALL have port p_ready, input, 1: downstream accepts p_data.
REQ-011 SHALL have port frame_err, output, 1: one-cycle pulse on framing violation.
REQ-012 SHALL have port err_count, output, 8: saturating count of framing violations.

Function
REQ-013 Serial bit accepted iff s_valid && s_ready on a rising edge; parallel word delivered iff p_valid && p_ready.
REQ-014 Bit order MSB-first: first accepted bit of a frame lands in p_data[N-1], Nth in p_data[0].
REQ-015 Internal structure: assembly shift register plus bit counter cnt (0..N-1) plus one output holding register (p_data/p_valid); assembly of next word proceeds while output register is full.
REQ-016 s_ready = (cnt != N-1) || !p_valid || p_ready; combinational; no dependence on s_valid, s_data or s_last.
REQ-017 Accepted bit with cnt < N-1 and s_last=0: shift in, cnt increments.
REQ-018 Accepted bit with cnt == N-1 and s_last=1: complete word loaded into output register, p_valid=1 next cycle (latency 1 cycle from final bit handshake), cnt -> 0.
REQ-019 Same-cycle drain and load (p_valid && p_ready && final-bit accept): p_valid stays 1, p_data takes new word; no bubble, no loss.
REQ-020 Drain without load: p_valid -> 0 next cycle; p_data holds last value (don't-care for checker).
REQ-021 Early last (accepted bit with s_last=1, cnt < N-1): partial word discarded, cnt -> 0, frame_err=1 next cycle for exactly one cycle, no p_valid.
REQ-022 Missing last (accepted bit with cnt == N-1, s_last=0): word discarded, cnt -> 0, frame_err pulse as REQ-021, no p_valid, output register untouched.
REQ-023 err_count increments by 1 on each frame_err event, saturates at 255, never wraps.
REQ-024 While p_valid=1 and p_ready=0, p_data and p_valid SHALL remain stable.
REQ-025 s_valid=0 cycles between bits of a frame SHALL be tolerated with no state change.

Reset
REQ-026 rst_n=0 asynchronously forces: cnt=0, shift register=0, p_data=0, p_valid=0, frame_err=0, err_count=0; s_ready=1 follows.
REQ-027 Reset mid-frame or with undelivered word: all partial and held data discarded, no frame_err, first bit after release starts a new frame.
REQ-028 No bits accepted and no state change while rst_n=0.

Verification (N=4)
REQ-029 Bits 1,0,1,1 with s_last on 4th, p_ready=1 -> p_data=4'b1011, p_valid=1 one cycle after 4th handshake, frame_err=0.
REQ-030 p_ready=0 holding word 4'hA; send next frame 0,1,0,1 -> first 3 bits accepted, s_ready=0 at cnt=3; raise p_ready -> 4'hA delivered, 4th bit accepted same cycle, next cycle p_data=4'h5, p_valid=1.
REQ-031 s_last on 2nd bit -> frame_err one-cycle pulse, err_count=1, no p_valid; following good frame 1,1,0,0 -> p_data=4'hC.
REQ-032 4 bits with s_last=0 on 4th -> frame_err pulse, err_count increments, p_valid unchanged.
REQ-033 260 framing violations -> err_count stops at 255.
REQ-034 rst_n=0 after 2 bits with p_valid=1 -> all outputs 0 immediately, s_ready=1; next 4-bit frame 0,0,0,1 -> p_data=4'h1.
